// File: rtl/odd_counter_pkg.sv
// Shared types and default sizing for the odd-counter stage and its downstream checker.
package odd_counter_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_STEP      = 2;
    localparam int unsigned DEF_ERR_CNT_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

endpackage : odd_counter_pkg

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clr,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            count_q <= '0;
        end else if (Inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign Count = count_q;

endmodule : sat_counter

// File: rtl/odd_seq_checker.sv
// Monitors a valid/ready stream of odd counter values spaced by STEP and reports
// lock state, error statistics and a capture of the first error seen.
module odd_seq_checker
    import odd_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned STEP      = DEF_STEP,
    parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 In_valid,
    output logic                 In_ready,
    input  logic [WIDTH-1:0]     In_count,
    input  logic                 Clear,
    output logic                 Locked,
    output logic                 Err_flag,
    output logic [ERR_CNT_W-1:0] Err_count,
    output logic [ERR_CNT_W-1:0] Sample_count,
    output logic [WIDTH-1:0]     First_err_expected,
    output logic [WIDTH-1:0]     First_err_actual
);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             locked_q, locked_d;
    logic             err_flag_q, err_flag_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_act_q, first_act_d;
    logic             accept;
    logic             err;
    logic [WIDTH-1:0] err_expected;
    logic             sample_odd;

    assign In_ready   = ~Rst & ~Clear;
    assign accept     = In_valid & In_ready;
    assign sample_odd = In_count[0];

    // Sequence tracking and first-error capture; only an accepted sample moves anything.
    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        err          = 1'b0;
        err_expected = expected_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (sample_odd) begin
                        state_d    = LOCKED;
                        expected_d = In_count + WIDTH'(STEP);
                    end else begin
                        err          = 1'b1;
                        err_expected = In_count | WIDTH'(1);
                    end
                end
                LOCKED: begin
                    if (In_count == expected_q) begin
                        expected_d = expected_q + WIDTH'(STEP);
                    end else begin
                        err = 1'b1;
                        if (sample_odd) begin
                            expected_d = In_count + WIDTH'(STEP);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d    = (state_d == LOCKED);
        err_flag_d  = err_flag_q | err;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        if (err && !err_flag_q) begin
            first_exp_d = err_expected;
            first_act_d = In_count;
        end
    end

    // Clear has the same effect on status as reset, for a single cycle.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            locked_q    <= locked_d;
            err_flag_q  <= err_flag_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (Clear),
        .Inc   (err),
        .Count (Err_count)
    );

    sat_counter #(.W(ERR_CNT_W)) u_sample_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clr   (Clear),
        .Inc   (accept),
        .Count (Sample_count)
    );

    assign Locked             = locked_q;
    assign Err_flag           = err_flag_q;
    assign First_err_expected = first_exp_q;
    assign First_err_actual   = first_act_q;

endmodule : odd_seq_checker

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench: a 16-bit and a 2-bit-counter checker share one stimulus stream.
module tb_odd_seq_checker;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Clear = 1'b0;
    logic        In_valid = 1'b0;
    logic [31:0] In_count = '0;

    logic        rdy_a, lck_a, flg_a;
    logic [15:0] errs_a, samps_a;
    logic [31:0] fe_a, fa_a;
    logic        rdy_b, lck_b, flg_b;
    logic [1:0]  errs_b, samps_b;
    logic [31:0] fe_b, fa_b;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 Clk = ~Clk;

    odd_seq_checker dut_a (
        .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(rdy_a), .In_count(In_count),
        .Clear(Clear), .Locked(lck_a), .Err_flag(flg_a), .Err_count(errs_a),
        .Sample_count(samps_a), .First_err_expected(fe_a), .First_err_actual(fa_a)
    );

    odd_seq_checker #(.WIDTH(32), .STEP(2), .ERR_CNT_W(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(rdy_b), .In_count(In_count),
        .Clear(Clear), .Locked(lck_b), .Err_flag(flg_b), .Err_count(errs_b),
        .Sample_count(samps_b), .First_err_expected(fe_b), .First_err_actual(fa_b)
    );

    typedef struct {
        logic        rdy;
        logic        lck;
        logic        flg;
        int unsigned errs;
        int unsigned samps;
        logic [31:0] fe;
        logic [31:0] fa;
    } exp_t;

    exp_t q[$];

    // Reference model state
    bit          m_ref = 0;
    longint      m_exp = 0;
    bit          m_flag = 0;
    int unsigned m_errs = 0;
    int unsigned m_samps = 0;
    logic [31:0] m_fe = '0;
    logic [31:0] m_fa = '0;

    function automatic int unsigned sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_err(input logic [31:0] e, input logic [31:0] a);
        if (!m_flag) begin
            m_fe = e;
            m_fa = a;
        end
        m_flag = 1;
        m_errs++;
    endtask

    // Drive one cycle of inputs and push the status expected after the next edge.
    task automatic step(input bit r, input bit c, input bit v, input logic [31:0] d);
        exp_t e;
        @(negedge Clk);
        Rst = r; Clear = c; In_valid = v; In_count = d;
        if (r || c) begin
            m_ref = 0; m_exp = 0; m_flag = 0; m_errs = 0; m_samps = 0; m_fe = '0; m_fa = '0;
        end else if (v) begin
            m_samps++;
            if (!m_ref) begin
                if (d % 2 == 1) begin
                    m_ref = 1;
                    m_exp = (longint'(d) + 2) % 64'h1_0000_0000;
                end else begin
                    model_err(d + 32'd1, d);
                end
            end else if (longint'(d) == m_exp) begin
                m_exp = (m_exp + 2) % 64'h1_0000_0000;
            end else begin
                model_err(32'(m_exp), d);
                if (d % 2 == 1) m_exp = (longint'(d) + 2) % 64'h1_0000_0000;
                else m_ref = 0;
            end
        end
        e.rdy = !(r || c);
        e.lck = m_ref;
        e.flg = m_flag;
        e.errs = m_errs;
        e.samps = m_samps;
        e.fe = m_fe;
        e.fa = m_fa;
        q.push_back(e);
    endtask

    task automatic send(input logic [31:0] d);
        step(0, 0, 1, d);
    endtask

    // Monitor: status is presented after every edge; pop and compare each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("ready_a",  64'(rdy_a), 64'(e.rdy));
                check("ready_b",  64'(rdy_b), 64'(e.rdy));
                check("locked_a", 64'(lck_a), 64'(e.lck));
                check("locked_b", 64'(lck_b), 64'(e.lck));
                check("errflag_a", 64'(flg_a), 64'(e.flg));
                check("errflag_b", 64'(flg_b), 64'(e.flg));
                check("errcnt_a", 64'(errs_a), 64'(sat(e.errs, 65535)));
                check("errcnt_b", 64'(errs_b), 64'(sat(e.errs, 3)));
                check("samples_a", 64'(samps_a), 64'(sat(e.samps, 65535)));
                check("samples_b", 64'(samps_b), 64'(sat(e.samps, 3)));
                check("first_exp_a", 64'(fe_a), 64'(e.fe));
                check("first_act_a", 64'(fa_a), 64'(e.fa));
                check("first_exp_b", 64'(fe_b), 64'(e.fe));
                check("first_act_b", 64'(fa_b), 64'(e.fa));
            end
        end
    end

    initial begin
        bit          r, c, v;
        logic [31:0] d;

        // 1: clean run after reset
        step(1, 0, 0, 0); step(1, 0, 1, 32'd9);
        send(1); send(3); send(5); send(7);
        step(0, 0, 0, 32'd9);

        // 2: even first sample
        step(1, 0, 0, 0);
        send(4);
        step(0, 0, 0, 0);

        // 3: skip with odd resync
        step(1, 0, 0, 0);
        send(1); send(3); send(7); send(9);

        // 4: wraparound
        step(1, 0, 0, 0);
        send(32'hFFFF_FFFD); send(32'hFFFF_FFFF); send(32'h0000_0001);

        // 5: clear drops an offered sample
        send(32'd6);
        step(0, 1, 1, 32'd11);
        step(0, 0, 0, 0);
        send(32'd13);
        send(32'd15);

        // 6: saturation, then reset mid-stream
        step(1, 0, 0, 0);
        send(2); send(4); send(6); send(8); send(10);
        send(11);
        step(1, 0, 1, 32'd13);
        send(32'd20);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 100) < 2;
            c = ($urandom % 100) < 3;
            v = ($urandom % 4) != 0;
            case ($urandom % 8)
                0, 1:    d = $urandom;
                2:       d = $urandom | 32'd1;
                3:       d = 32'hFFFF_FFFF - 32'(2 * ($urandom % 3));
                default: d = m_ref ? 32'(m_exp) : ($urandom | 32'd1);
            endcase
            step(r, c, v, d);
        end
        step(0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge Clk);
        repeat (2) @(posedge Clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_odd_seq_checker
